// File: rtl/ahb_sram_slave_pkg.sv
// ahb_pkg: shared AHB encodings and slave state type for the SRAM responder.
//   HTRANS_* : transfer type codes
//   HSIZE_*  : transfer size codes (byte/half/word)
//   HRESP_*  : response codes
//   slv_state_e : responder FSM states
//   aphase_t    : captured address-phase request
//   byte_en()   : little-endian byte lane enables from size and address offset
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HSIZE_B = 3'd0;
   localparam logic [2:0] HSIZE_H = 3'd1;
   localparam logic [2:0] HSIZE_W = 3'd2;

   localparam logic [1:0] HRESP_OKAY  = 2'd0;
   localparam logic [1:0] HRESP_ERROR = 2'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_LAST,
      ST_ERR1,
      ST_ERR2
   } slv_state_e;

   typedef struct packed {
      logic       write;
      logic [3:0] be;
   } aphase_t;

   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
      case (size)
         HSIZE_B: byte_en = 4'b0001 << off;
         HSIZE_H: byte_en = off[1] ? 4'b1100 : 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB slave-side bus bundle for the SRAM responder.
//   master -> slave : hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata
//   interconnect    : hready (bus-wide ready, input to both sides)
//   slave -> master : hreadyout, hrdata, hresp
interface ahb_sram_slave_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  hsel;
   logic [ADDR_WIDTH-1:0] haddr;
   logic [1:0]            htrans;
   logic [2:0]            hsize;
   logic [2:0]            hburst;
   logic [3:0]            hprot;
   logic                  hwrite;
   logic [31:0]           hwdata;
   logic                  hready;
   logic                  hreadyout;
   logic [31:0]           hrdata;
   logic [1:0]            hresp;

   modport slave (
      input  hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata, hready,
      output hreadyout, hrdata, hresp
   );

   modport master (
      output hsel, haddr, htrans, hsize, hburst, hprot, hwrite, hwdata,
      input  hready, hreadyout, hrdata, hresp
   );
endinterface

// File: rtl/ahb_sram_slave_bank.sv
// ahb_sram_bank: MEM_DEPTH x 32 SRAM, byte write enables, registered read data.
//   hclk    : clock
//   i_we    : per-byte write enable, i_waddr/i_wdata : write word index / data
//   i_re    : read enable, i_raddr : read word index
//   o_rdata : registered read word; holds until the next i_re
// One write and one read per edge. A read of the word being written on the
// same edge returns the old contents; the slave forwards the new bytes.
module ahb_sram_bank #(
   parameter int MEM_DEPTH = 4096
) (
   input  logic                         hclk,
   input  logic [3:0]                   i_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_waddr,
   input  logic [31:0]                  i_wdata,
   input  logic                         i_re,
   input  logic [$clog2(MEM_DEPTH)-1:0] i_raddr,
   output logic [31:0]                  o_rdata
);

   logic [31:0] r_mem [MEM_DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge hclk) begin
      for (int l = 0; l < 4; l++) begin
         if (i_we[l]) r_mem[i_waddr][8*l +: 8] <= i_wdata[8*l +: 8];
      end
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB single-transfer responder in front of on-chip SRAM.
//   hclk, hreset_n : clock, asynchronous active-low reset
//   ahb            : slave modport (select/address/control/wdata in,
//                    hreadyout/hrdata/hresp out)
// Byte/half/word access, WAIT_STATES wait cycles per OKAY transfer,
// two-cycle ERROR for misaligned/oversized/out-of-range accesses, and
// forwarding of a write committing on the same edge a read of that word
// is accepted.
module ahb_sram_slave
   import ahb_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int MEM_DEPTH   = 4096,
   parameter int WAIT_STATES = 0
) (
   input  logic              hclk,
   input  logic              hreset_n,
   ahb_sram_slave_if.slave   ahb
);

   localparam int         IW        = $clog2(MEM_DEPTH);
   localparam logic [2:0] WCNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   slv_state_e    r_state, w_state_nxt;
   aphase_t       r_req;
   logic [IW-1:0] r_idx;
   logic [2:0]    r_wcnt;
   logic          r_bypass;
   logic [3:0]    r_byp_be;
   logic [31:0]   r_byp_data;

   logic [IW-1:0] w_idx;
   logic [3:0]    w_be;
   logic          w_open;
   logic          w_accept;
   logic          w_illegal;
   logic          w_go;
   logic          w_commit;
   logic          w_hreadyout;
   logic [1:0]    w_hresp;
   logic [31:0]   w_ram_rdata;
   logic [31:0]   w_rd_word;
   logic          w_unused;

   // Address-phase decode
   assign w_idx  = ahb.haddr[IW+1:2];
   assign w_be   = byte_en(ahb.hsize, ahb.haddr[1:0]);
   // States where hreadyout is high and a new address phase can be taken
   assign w_open = (r_state == ST_IDLE) || (r_state == ST_LAST) || (r_state == ST_ERR2);
   assign w_accept = ahb.hsel && ahb.htrans[1] && ahb.hready && w_open;

   assign w_illegal = (ahb.hsize > HSIZE_W)
                   || ((ahb.hsize == HSIZE_H) && ahb.haddr[0])
                   || ((ahb.hsize == HSIZE_W) && (ahb.haddr[1:0] != 2'b00))
                   || ({1'b0, w_idx} >= (IW+1)'(MEM_DEPTH));

   assign w_go     = w_accept && !w_illegal;
   assign w_commit = (r_state == ST_LAST) && r_req.write;

   // hburst/hprot carry nothing for a single-transfer SRAM; upper address
   // bits belong to the decoder.
   assign w_unused = ^{ahb.hburst, ahb.hprot, ahb.haddr};

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hreadyout = 1'b1;
      w_hresp     = HRESP_OKAY;
      case (r_state)
         ST_IDLE, ST_LAST, ST_ERR2: begin
            if (r_state == ST_ERR2) w_hresp = HRESP_ERROR;
            w_state_nxt = ST_IDLE;
            if (w_accept) begin
               if (w_illegal)            w_state_nxt = ST_ERR1;
               else if (WAIT_STATES > 0) w_state_nxt = ST_WAIT;
               else                      w_state_nxt = ST_LAST;
            end
         end
         ST_WAIT: begin
            w_hreadyout = 1'b0;
            if (r_wcnt == 3'd0) w_state_nxt = ST_LAST;
         end
         ST_ERR1: begin
            w_hreadyout = 1'b0;
            w_hresp     = HRESP_ERROR;
            w_state_nxt = ST_ERR2;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         r_req      <= '0;
         r_idx      <= '0;
         r_wcnt     <= '0;
         r_bypass   <= 1'b0;
         r_byp_be   <= '0;
         r_byp_data <= '0;
      end else begin
         if (w_go) begin
            r_idx      <= w_idx;
            r_req      <= '{write: ahb.hwrite, be: w_be};
            r_wcnt     <= WCNT_INIT;
            // The bank read launched on this edge sees the pre-write word;
            // keep the committing bytes to overlay in the read's LAST cycle.
            r_bypass   <= w_commit && !ahb.hwrite && (w_idx == r_idx);
            r_byp_be   <= r_req.be;
            r_byp_data <= ahb.hwdata;
         end else if ((r_state == ST_WAIT) && (r_wcnt != 3'd0)) begin
            r_wcnt <= r_wcnt - 3'd1;
         end
      end
   end

   ahb_sram_bank #(
      .MEM_DEPTH(MEM_DEPTH)
   ) u_bank (
      .hclk    (hclk),
      .i_we    (w_commit ? r_req.be : 4'b0000),
      .i_waddr (r_idx),
      .i_wdata (ahb.hwdata),
      .i_re    (w_go && !ahb.hwrite),
      .i_raddr (w_idx),
      .o_rdata (w_ram_rdata)
   );

   always_comb begin
      w_rd_word = w_ram_rdata;
      if (r_bypass) begin
         for (int l = 0; l < 4; l++) begin
            if (r_byp_be[l]) w_rd_word[8*l +: 8] = r_byp_data[8*l +: 8];
         end
      end
   end

   assign ahb.hreadyout = w_hreadyout;
   assign ahb.hresp     = w_hresp;
   assign ahb.hrdata    = ((r_state == ST_LAST) && !r_req.write) ? w_rd_word : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three responders (0, 2 and 3 wait states) share one
// master driver; 'sel' routes hsel to one of them and picks which
// response is observed.
module tb_ahb_sram_slave;
   import ahb_pkg::*;

   logic        hclk, hreset_n;
   logic [1:0]  sel;
   logic        t_hsel, t_hwrite;
   logic [31:0] t_haddr, t_hwdata;
   logic [1:0]  t_htrans;
   logic [2:0]  t_hsize;
   int          checks, failures;

   logic        m_ready;
   logic [1:0]  m_resp;
   logic [31:0] m_rdata;
   logic [31:0] rd;
   int          waits;
   logic [1:0]  rf, rl;

   ahb_sram_slave_if #(.ADDR_WIDTH(32)) bus0 ();
   ahb_sram_slave_if #(.ADDR_WIDTH(32)) bus2 ();
   ahb_sram_slave_if #(.ADDR_WIDTH(32)) bus3 ();

   assign bus0.hsel = t_hsel && (sel == 2'd0);
   assign bus0.haddr = t_haddr;  assign bus0.htrans = t_htrans; assign bus0.hsize = t_hsize;
   assign bus0.hburst = 3'd0;    assign bus0.hprot = 4'd0;      assign bus0.hwrite = t_hwrite;
   assign bus0.hwdata = t_hwdata; assign bus0.hready = bus0.hreadyout;

   assign bus2.hsel = t_hsel && (sel == 2'd1);
   assign bus2.haddr = t_haddr;  assign bus2.htrans = t_htrans; assign bus2.hsize = t_hsize;
   assign bus2.hburst = 3'd0;    assign bus2.hprot = 4'd0;      assign bus2.hwrite = t_hwrite;
   assign bus2.hwdata = t_hwdata; assign bus2.hready = bus2.hreadyout;

   assign bus3.hsel = t_hsel && (sel == 2'd2);
   assign bus3.haddr = t_haddr;  assign bus3.htrans = t_htrans; assign bus3.hsize = t_hsize;
   assign bus3.hburst = 3'd0;    assign bus3.hprot = 4'd0;      assign bus3.hwrite = t_hwrite;
   assign bus3.hwdata = t_hwdata; assign bus3.hready = bus3.hreadyout;

   ahb_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(4096), .WAIT_STATES(0)) u_dut0 (
      .hclk(hclk), .hreset_n(hreset_n), .ahb(bus0));
   ahb_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(1000), .WAIT_STATES(2)) u_dut2 (
      .hclk(hclk), .hreset_n(hreset_n), .ahb(bus2));
   ahb_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(4096), .WAIT_STATES(3)) u_dut3 (
      .hclk(hclk), .hreset_n(hreset_n), .ahb(bus3));

   assign m_ready = (sel == 2'd0) ? bus0.hreadyout : (sel == 2'd1) ? bus2.hreadyout : bus3.hreadyout;
   assign m_resp  = (sel == 2'd0) ? bus0.hresp     : (sel == 2'd1) ? bus2.hresp     : bus3.hresp;
   assign m_rdata = (sel == 2'd0) ? bus0.hrdata    : (sel == 2'd1) ? bus2.hrdata    : bus3.hrdata;

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Non-pipelined single transfer; returns data-phase wait count and the
   // response seen in the first and last data-phase cycles.
   task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, output logic [31:0] rdo, output int nw,
                       output logic [1:0] r_first, output logic [1:0] r_last);
      @(posedge hclk); #1;
      t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_haddr = a; t_hsize = sz; t_hwrite = w;
      @(posedge hclk); #1;
      t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_hwdata = wd;
      nw = 0;
      @(negedge hclk);
      r_first = m_resp;
      while (!m_ready && nw < 20) begin
         nw++;
         @(negedge hclk);
      end
      rdo = m_rdata; r_last = m_resp;
   endtask

   initial begin
      checks = 0; failures = 0;
      sel = 2'd0; t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_haddr = '0;
      t_hsize = HSIZE_W; t_hwrite = 1'b0; t_hwdata = '0;
      hreset_n = 1'b0;
      repeat (3) @(posedge hclk);
      @(negedge hclk);
      chk("rst_ready", 32'(m_ready), 32'd1);
      chk("rst_resp",  32'(m_resp),  32'd0);
      chk("rst_rdata", m_rdata,      32'h0);
      @(posedge hclk); #1; hreset_n = 1'b1;

      // ---- 0 wait states: back-to-back write then read of the same word
      sel = 2'd0;
      @(posedge hclk); #1;
      t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_haddr = 32'h10; t_hsize = HSIZE_W; t_hwrite = 1'b1;
      @(posedge hclk); #1;
      t_hwrite = 1'b0; t_hwdata = 32'hDEADBEEF;
      @(negedge hclk);
      chk("b2b_wr_ready", 32'(m_ready), 32'd1);
      @(posedge hclk); #1;
      t_hsel = 1'b0; t_htrans = HTRANS_IDLE;
      @(negedge hclk);
      chk("b2b_rd_ready", 32'(m_ready), 32'd1);
      chk("b2b_rd_resp",  32'(m_resp),  32'd0);
      chk("b2b_bypass",   m_rdata,      32'hDEADBEEF);
      xfer(1'b0, 32'h10, HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("ws0_rd_waits", 32'(waits), 32'd0);
      chk("ws0_rd_data",  rd,         32'hDEADBEEF);

      // ---- 2 wait states: byte merge
      sel = 2'd1;
      xfer(1'b1, 32'h20, HSIZE_W, 32'h11223344, rd, waits, rf, rl);
      chk("ws2_wr_waits", 32'(waits), 32'd2);
      xfer(1'b1, 32'h21, HSIZE_B, 32'h0000AA00, rd, waits, rf, rl);
      chk("ws2_bwr_waits", 32'(waits), 32'd2);
      chk("ws2_bwr_resp",  32'(rl),    32'd0);
      xfer(1'b0, 32'h20, HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("ws2_rd_waits", 32'(waits), 32'd2);
      chk("byte_merge",   rd,         32'h1122AA44);

      // half write to lanes 3:2
      xfer(1'b1, 32'h30, HSIZE_W, 32'hCAFEF00D, rd, waits, rf, rl);
      xfer(1'b1, 32'h32, HSIZE_H, 32'h55660000, rd, waits, rf, rl);
      xfer(1'b0, 32'h30, HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("half_merge", rd, 32'h5566F00D);

      // misaligned word -> two-cycle ERROR, no write
      xfer(1'b1, 32'h00, HSIZE_W, 32'h01020304, rd, waits, rf, rl);
      xfer(1'b1, 32'h02, HSIZE_W, 32'hFFFFFFFF, rd, waits, rf, rl);
      chk("err_word_waits", 32'(waits), 32'd1);
      chk("err_word_resp1", 32'(rf),    32'd1);
      chk("err_word_resp2", 32'(rl),    32'd1);
      // misaligned half
      xfer(1'b1, 32'h01, HSIZE_H, 32'hFFFFFFFF, rd, waits, rf, rl);
      chk("err_half_waits", 32'(waits), 32'd1);
      chk("err_half_resp",  32'(rl),    32'd1);
      xfer(1'b0, 32'h00, HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("err_no_write", rd, 32'h01020304);

      // index == MEM_DEPTH (1000 words) and hsize=3
      xfer(1'b0, 32'(1000 * 4), HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("err_oob_waits", 32'(waits), 32'd1);
      chk("err_oob_resp1", 32'(rf),    32'd1);
      chk("err_oob_resp2", 32'(rl),    32'd1);
      chk("err_oob_rdata", rd,         32'h0);
      xfer(1'b0, 32'h00, 3'd3, 32'h0, rd, waits, rf, rl);
      chk("err_size_waits", 32'(waits), 32'd1);
      chk("err_size_resp",  32'(rl),    32'd1);
      chk("err_size_rdata", rd,         32'h0);
      // last legal index still works
      xfer(1'b1, 32'(999 * 4), HSIZE_W, 32'h0BADF00D, rd, waits, rf, rl);
      chk("top_wr_resp", 32'(rl), 32'd0);
      xfer(1'b0, 32'(999 * 4), HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("top_rd_data", rd, 32'h0BADF00D);

      // IDLE / BUSY / hsel=0: no action
      @(posedge hclk); #1;
      t_hsel = 1'b1; t_htrans = HTRANS_IDLE; t_haddr = 32'h0; t_hsize = HSIZE_W; t_hwrite = 1'b1;
      @(posedge hclk); #1;
      t_htrans = HTRANS_BUSY; t_hwdata = 32'hFFFFFFFF;
      @(negedge hclk);
      chk("idle_ready", 32'(m_ready), 32'd1);
      chk("idle_resp",  32'(m_resp),  32'd0);
      @(posedge hclk); #1;
      t_hsel = 1'b0; t_htrans = HTRANS_SEQ;
      @(negedge hclk);
      chk("busy_ready", 32'(m_ready), 32'd1);
      chk("busy_resp",  32'(m_resp),  32'd0);
      @(posedge hclk); #1;
      t_htrans = HTRANS_IDLE;
      @(negedge hclk);
      chk("nosel_ready", 32'(m_ready), 32'd1);
      chk("nosel_resp",  32'(m_resp),  32'd0);
      xfer(1'b0, 32'h00, HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("nop_no_write", rd, 32'h01020304);

      // ---- 3 wait states: reset in the middle of a write
      sel = 2'd2;
      xfer(1'b1, 32'h40, HSIZE_W, 32'h12345678, rd, waits, rf, rl);
      chk("ws3_wr_waits", 32'(waits), 32'd3);
      @(posedge hclk); #1;
      t_hsel = 1'b1; t_htrans = HTRANS_NONSEQ; t_haddr = 32'h40; t_hsize = HSIZE_W; t_hwrite = 1'b1;
      @(posedge hclk); #1;
      t_hsel = 1'b0; t_htrans = HTRANS_IDLE; t_hwdata = 32'h9ABCDEF0;
      @(negedge hclk);
      chk("ws3_in_wait", 32'(m_ready), 32'd0);
      #1 hreset_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(m_ready), 32'd1);
      chk("midrst_resp",  32'(m_resp),  32'd0);
      chk("midrst_rdata", m_rdata,      32'h0);
      @(posedge hclk); @(posedge hclk); #1;
      hreset_n = 1'b1;
      xfer(1'b0, 32'h40, HSIZE_W, 32'h0, rd, waits, rf, rl);
      chk("ws3_rd_waits",   32'(waits), 32'd3);
      chk("midrst_nowrite", rd,         32'h12345678);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
